// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit saturating-counter branch direction predictor with statistics
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [31:0] ex_pc,
  input  logic        ex_branch_ctrl,
  input  logic        ex_pred_taken,
  output logic        mispredict,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int         ENTRIES    = 1 << INDEX_BITS;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [1:0] WEAK_NT    = 2'b01;

  logic [1:0]            table_q [ENTRIES];
  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic                  is_branch;
  logic                  unused_pc_bits;

  // Word-aligned PCs: drop the byte offset, no tags so aliasing PCs share an entry
  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];

  assign unused_pc_bits = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0],
                            ex_pc[31:INDEX_BITS+2], ex_pc[1:0]};

  // Only conditional branches train the table; JAL/JALR and everything else are ignored
  assign is_branch = ex_valid & (ex_opcode == OPC_BRANCH);

  // Flush request goes straight to the pipeline, suppressed while in reset
  assign mispredict = ~rst & is_branch & (ex_branch_ctrl ^ ex_pred_taken);

  // Counter table: reset to weak not-taken, saturating train on each resolved branch
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= WEAK_NT;
      end
    end else if (is_branch) begin
      if (ex_branch_ctrl) begin
        if (table_q[ex_idx] != 2'b11) begin
          table_q[ex_idx] <= table_q[ex_idx] + 2'b01;
        end
      end else begin
        if (table_q[ex_idx] != 2'b00) begin
          table_q[ex_idx] <= table_q[ex_idx] - 2'b01;
        end
      end
    end
  end

  // Registered lookup; the nonblocking table write gives read-before-write on collisions
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else if (if_valid) begin
      pred_valid <= 1'b1;
      pred_taken <= table_q[if_idx][1];
    end else begin
      pred_valid <= 1'b0;
    end
  end

  // Statistics counters, free-running and wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt <= 32'd0;
      miss_cnt   <= 32'd0;
    end else begin
      if (is_branch) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (mispredict) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [31:0] ex_pc;
  logic        ex_branch_ctrl;
  logic        ex_pred_taken;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int passed = 0;

  // Reference model: per-entry counter as a plain integer 0..3
  int          m_ctr [64];
  bit          m_pv;
  bit          m_pt;
  bit [31:0]   m_bc;
  bit [31:0]   m_mc;
  logic        obs_mis;
  bit          exp_mis;

  branch_predictor #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
    .ex_branch_ctrl(ex_branch_ctrl), .ex_pred_taken(ex_pred_taken),
    .mispredict(mispredict), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive inputs, sample mispredict mid-cycle, advance the model, step the clock
  task automatic drive(input bit r, input bit ifv, input logic [31:0] ipc,
                       input bit exv, input logic [6:0] op, input logic [31:0] epc,
                       input bit ctrl, input bit ptk);
    int  li;
    int  ei;
    bit  isb;
    rst = r; if_valid = ifv; if_pc = ipc;
    ex_valid = exv; ex_opcode = op; ex_pc = epc;
    ex_branch_ctrl = ctrl; ex_pred_taken = ptk;
    #1;
    obs_mis = mispredict;
    li  = int'((ipc >> 2) % 64);
    ei  = int'((epc >> 2) % 64);
    isb = exv && (op == OPC_BR);
    exp_mis = !r && isb && (ctrl != ptk);
    if (r) begin
      foreach (m_ctr[i]) m_ctr[i] = 1;
      m_pv = 0; m_pt = 0; m_bc = 0; m_mc = 0;
    end else begin
      if (ifv) begin
        m_pv = 1;
        m_pt = (m_ctr[li] >= 2);
      end else begin
        m_pv = 0;
      end
      if (isb) begin
        m_bc = m_bc + 1;
        if (ctrl != ptk) m_mc = m_mc + 1;
        if (ctrl) m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
        else      m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    drive(0, 1, pc, 0, 7'd0, 32'd0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] pc, input bit ctrl, input bit ptk);
    drive(0, 0, 32'd0, 1, OPC_BR, pc, ctrl, ptk);
  endtask

  task automatic test_reset;
    drive(1, 0, 32'd0, 0, 7'd0, 32'd0, 0, 0);
    drive(1, 0, 32'd0, 0, 7'd0, 32'd0, 0, 0);
    checks++;
    if (pred_valid !== 1'b0) $display("FAIL reset_pred_valid got %0b want 0", pred_valid);
    else passed++;
    look(32'h100);
    checks++;
    if (pred_valid !== 1'b1) $display("FAIL reset_lookup_valid got %0b want 1", pred_valid);
    else passed++;
    checks++;
    if (pred_taken !== 1'b0) $display("FAIL reset_lookup_taken got %0b want 0", pred_taken);
    else passed++;
    checks++;
    if (branch_cnt !== 32'd0 || miss_cnt !== 32'd0)
      $display("FAIL reset_counts got %0d/%0d want 0/0", branch_cnt, miss_cnt);
    else passed++;
  endtask

  task automatic test_training;
    for (int k = 0; k < 3; k++) begin
      resolve(32'h100, 1, 0);
      checks++;
      if (obs_mis !== 1'b1) $display("FAIL train_mispredict[%0d] got %0b want 1", k, obs_mis);
      else passed++;
    end
    look(32'h100);
    checks++;
    if (pred_taken !== 1'b1) $display("FAIL train_lookup got %0b want 1", pred_taken);
    else passed++;
    checks++;
    if (branch_cnt !== 32'd3 || miss_cnt !== 32'd3)
      $display("FAIL train_counts got %0d/%0d want 3/3", branch_cnt, miss_cnt);
    else passed++;
  endtask

  task automatic test_saturation;
    bit exp_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      resolve(32'h100, 0, 1);
      checks++;
      if (obs_mis !== 1'b1) $display("FAIL sat_mispredict[%0d] got %0b want 1", k, obs_mis);
      else passed++;
      look(32'h100);
      checks++;
      if (pred_taken !== exp_seq[k])
        $display("FAIL sat_lookup[%0d] got %0b want %0b", k, pred_taken, exp_seq[k]);
      else passed++;
    end
    checks++;
    if (branch_cnt !== m_bc || miss_cnt !== m_mc)
      $display("FAIL sat_counts got %0d/%0d want %0d/%0d", branch_cnt, miss_cnt, m_bc, m_mc);
    else passed++;
  endtask

  task automatic test_alias_filter;
    bit [31:0] bc_before;
    resolve(32'h100, 1, 0);
    resolve(32'h100, 1, 0);
    look(32'h200);
    checks++;
    if (pred_taken !== 1'b1) $display("FAIL alias_lookup got %0b want 1", pred_taken);
    else passed++;
    bc_before = m_bc;
    drive(0, 0, 32'd0, 1, OPC_JAL, 32'h100, 1, 0);
    checks++;
    if (obs_mis !== 1'b0) $display("FAIL jal_mispredict got %0b want 0", obs_mis);
    else passed++;
    drive(0, 0, 32'd0, 0, OPC_BR, 32'h100, 0, 1);
    checks++;
    if (obs_mis !== 1'b0) $display("FAIL exinvalid_mispredict got %0b want 0", obs_mis);
    else passed++;
    checks++;
    if (branch_cnt !== bc_before) $display("FAIL filter_branch_cnt got %0d want %0d", branch_cnt, bc_before);
    else passed++;
    resolve(32'h100, 0, 1);
    look(32'h100);
    checks++;
    if (pred_taken !== 1'b0) $display("FAIL filter_counter got %0b want 0", pred_taken);
    else passed++;
  endtask

  task automatic test_collision;
    drive(0, 1, 32'h100, 1, OPC_BR, 32'h100, 1, 0);
    checks++;
    if (pred_taken !== 1'b0) $display("FAIL collision_read got %0b want 0", pred_taken);
    else passed++;
    look(32'h100);
    checks++;
    if (pred_taken !== 1'b1) $display("FAIL collision_after got %0b want 1", pred_taken);
    else passed++;
  endtask

  task automatic test_reset_mid;
    drive(1, 0, 32'd0, 1, OPC_BR, 32'h100, 1, 0);
    checks++;
    if (obs_mis !== 1'b0) $display("FAIL rstmid_mispredict got %0b want 0", obs_mis);
    else passed++;
    checks++;
    if (pred_valid !== 1'b0) $display("FAIL rstmid_pred_valid got %0b want 0", pred_valid);
    else passed++;
    look(32'h100);
    checks++;
    if (pred_taken !== 1'b0) $display("FAIL rstmid_lookup got %0b want 0", pred_taken);
    else passed++;
    checks++;
    if (branch_cnt !== 32'd0 || miss_cnt !== 32'd0)
      $display("FAIL rstmid_counts got %0d/%0d want 0/0", branch_cnt, miss_cnt);
    else passed++;
  endtask

  task automatic test_random;
    logic [6:0] op;
    int         sel;
    int         errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 6) ? OPC_BR : (sel < 8) ? OPC_JAL : 7'b0110011;
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
            32'($urandom_range(0, 255) * 4), $urandom_range(0, 3) != 0, op,
            32'($urandom_range(0, 255) * 4), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
      checks++;
      if (obs_mis !== exp_mis || pred_valid !== m_pv || pred_taken !== m_pt ||
          branch_cnt !== m_bc || miss_cnt !== m_mc) begin
        if (errs < 10)
          $display("FAIL random[%0d] got mis=%0b pv=%0b pt=%0b bc=%0d mc=%0d want mis=%0b pv=%0b pt=%0b bc=%0d mc=%0d",
                   n, obs_mis, pred_valid, pred_taken, branch_cnt, miss_cnt,
                   exp_mis, m_pv, m_pt, m_bc, m_mc);
        errs++;
      end else begin
        passed++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_pc = 32'd0;
    ex_valid = 1'b0; ex_opcode = 7'd0; ex_pc = 32'd0;
    ex_branch_ctrl = 1'b0; ex_pred_taken = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_training;
    test_saturation;
    test_alias_filter;
    test_collision;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
